// File: rtl/text_terminal_ctrl_pkg.sv
// Shared constants and FSM encoding for the UART-driven text terminal controller.
package text_terminal_ctrl_pkg;

    localparam logic [7:0] CMD_NEWLINE   = 8'h0D;
    localparam logic [7:0] CMD_CLEAR     = 8'h0C;
    localparam logic [7:0] CMD_BACKSPACE = 8'h7F;
    localparam logic [7:0] BLANK_GLYPH   = 8'h20;

    localparam int unsigned DEFAULT_COLUMNS   = 80;
    localparam int unsigned DEFAULT_ROWS      = 30;
    localparam logic [7:0]  DEFAULT_ATTRIBUTE = 8'b0111_0000;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WRITE,
        FILL
    } termState_t;

endpackage

// File: rtl/term_byte_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO succeeds only if a pop happens the same cycle.
module term_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PushValid,
    input  logic [7:0] PushData,
    input  logic       PopReady,
    output logic [7:0] PopData,
    output logic       Full,
    output logic       Empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             doPop;
    logic             doPush;

    assign Full    = (count == (PTR_W+1)'(DEPTH));
    assign Empty   = (count == '0);
    assign PopData = mem[rdPtr];
    assign doPop   = PopReady && !Empty;
    assign doPush  = PushValid && (!Full || doPop);

    always_ff @(posedge Clock) begin
        if (doPush && !Reset) begin
            mem[wrPtr] <= PushData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/text_terminal_ctrl.sv
// Decodes received bytes into TextRAM cell writes: glyphs, colour, newline, backspace, clear.
module text_terminal_ctrl
    import text_terminal_ctrl_pkg::*;
#(
    parameter int unsigned COLUMNS      = DEFAULT_COLUMNS,
    parameter int unsigned ROWS         = DEFAULT_ROWS,
    parameter logic [7:0]  DEFAULT_ATTR = DEFAULT_ATTRIBUTE,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Data_i,
    input  logic        DataValid_i,
    output logic        WrEnable_o,
    output logic [11:0] WrAddress_o,
    output logic [15:0] WrData_o,
    output logic [6:0]  CursorX_o,
    output logic [4:0]  CursorY_o,
    output logic        Busy_o,
    output logic        Overrun_o
);

    localparam logic [6:0]  LAST_COL    = 7'(COLUMNS - 1);
    localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
    localparam logic [11:0] ROW_STRIDE  = 12'(COLUMNS);
    localparam logic [11:0] ROW_LAST    = 12'(COLUMNS - 1);
    localparam logic [11:0] SCREEN_LAST = 12'(COLUMNS * ROWS - 1);

    termState_t  state, nextState;
    logic [7:0]  fifoData;
    logic        fifoEmpty, fifoFull, fifoPop;
    logic [7:0]  cmdByte, attr, wrGlyph;
    logic [6:0]  cursorX;
    logic [4:0]  cursorY;
    logic [11:0] curAddr, rowBase, wrAddr, fillAddr, fillLeft, nextRowBase;
    logic        wrapPending, overrun;
    logic        isColour, isNewline, isClear, isBackspace, bsNoop, atLastCol, atLastRow;

    term_byte_fifo #(.DEPTH(FIFO_DEPTH)) byteFifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .PushValid (DataValid_i && !Reset),
        .PushData  (Data_i),
        .PopReady  (fifoPop),
        .PopData   (fifoData),
        .Full      (fifoFull),
        .Empty     (fifoEmpty)
    );

    assign fifoPop     = (state == IDLE) && !fifoEmpty;
    assign isColour    = cmdByte[7];
    assign isNewline   = (cmdByte == CMD_NEWLINE);
    assign isClear     = (cmdByte == CMD_CLEAR);
    assign isBackspace = (cmdByte == CMD_BACKSPACE);
    assign bsNoop      = isBackspace && (cursorX == '0) && (cursorY == '0);
    assign atLastCol   = (cursorX == LAST_COL);
    assign atLastRow   = (cursorY == LAST_ROW);
    assign nextRowBase = atLastRow ? '0 : rowBase + ROW_STRIDE;

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (!fifoEmpty) nextState = DECODE;
            DECODE: begin
                if (isColour || bsNoop)      nextState = IDLE;
                else if (isClear || isNewline) nextState = FILL;
                else                         nextState = WRITE;
            end
            WRITE:  nextState = wrapPending ? FILL : IDLE;
            FILL:   if (fillLeft == '0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Cursor/address move when the command is decoded, so they already show the
    // final position during the write(s) that complete the command.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cmdByte     <= '0;
            attr        <= DEFAULT_ATTR;
            cursorX     <= '0;
            cursorY     <= '0;
            curAddr     <= '0;
            rowBase     <= '0;
            wrAddr      <= '0;
            wrGlyph     <= '0;
            fillAddr    <= '0;
            fillLeft    <= '0;
            wrapPending <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= DataValid_i && fifoFull && !fifoPop;
            case (state)
                IDLE: if (fifoPop) cmdByte <= fifoData;
                DECODE: begin
                    if (isColour) begin
                        attr <= {1'b0, cmdByte[6:0]};
                    end else if (isClear) begin
                        attr     <= DEFAULT_ATTR;
                        cursorX  <= '0;
                        cursorY  <= '0;
                        curAddr  <= '0;
                        rowBase  <= '0;
                        fillAddr <= '0;
                        fillLeft <= SCREEN_LAST;
                    end else if (isBackspace) begin
                        if (!bsNoop) begin
                            if (cursorX != '0) begin
                                cursorX <= cursorX - 1'b1;
                            end else begin
                                cursorX <= LAST_COL;
                                cursorY <= cursorY - 1'b1;
                                rowBase <= rowBase - ROW_STRIDE;
                            end
                            curAddr <= curAddr - 1'b1;
                            wrAddr  <= curAddr - 1'b1;
                            wrGlyph <= BLANK_GLYPH;
                        end
                    end else begin
                        if (!isNewline) begin
                            wrAddr  <= curAddr;
                            wrGlyph <= cmdByte;
                        end
                        if (isNewline || atLastCol) begin
                            cursorX     <= '0;
                            cursorY     <= atLastRow ? '0 : cursorY + 1'b1;
                            rowBase     <= nextRowBase;
                            curAddr     <= nextRowBase;
                            fillAddr    <= nextRowBase;
                            fillLeft    <= ROW_LAST;
                            wrapPending <= !isNewline;
                        end else begin
                            cursorX <= cursorX + 1'b1;
                            curAddr <= curAddr + 1'b1;
                        end
                    end
                end
                WRITE: wrapPending <= 1'b0;
                FILL: begin
                    fillAddr <= fillAddr + 1'b1;
                    fillLeft <= fillLeft - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        WrEnable_o  = 1'b0;
        WrAddress_o = '0;
        WrData_o    = '0;
        if (state == WRITE) begin
            WrEnable_o  = 1'b1;
            WrAddress_o = wrAddr;
            WrData_o    = {attr, wrGlyph};
        end else if (state == FILL) begin
            WrEnable_o  = 1'b1;
            WrAddress_o = fillAddr;
            WrData_o    = {attr, BLANK_GLYPH};
        end
    end

    assign CursorX_o = cursorX;
    assign CursorY_o = cursorY;
    assign Busy_o    = (state != IDLE) || !fifoEmpty;
    assign Overrun_o = overrun;

endmodule

// File: tb/tb_text_terminal_ctrl.sv
// Directed self-checking bench for text_terminal_ctrl with a write logger.
module tb_text_terminal_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Data_i = '0;
    logic        DataValid_i = 1'b0;
    logic        WrEnable_o;
    logic [11:0] WrAddress_o;
    logic [15:0] WrData_o;
    logic [6:0]  CursorX_o;
    logic [4:0]  CursorY_o;
    logic        Busy_o;
    logic        Overrun_o;

    int total = 0;
    int bad = 0;
    int overrunCount = 0;
    logic [11:0] qAddr[$];
    logic [15:0] qData[$];

    text_terminal_ctrl #(
        .COLUMNS      (80),
        .ROWS         (30),
        .DEFAULT_ATTR (8'b0111_0000),
        .FIFO_DEPTH   (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Data_i      (Data_i),
        .DataValid_i (DataValid_i),
        .WrEnable_o  (WrEnable_o),
        .WrAddress_o (WrAddress_o),
        .WrData_o    (WrData_o),
        .CursorX_o   (CursorX_o),
        .CursorY_o   (CursorY_o),
        .Busy_o      (Busy_o),
        .Overrun_o   (Overrun_o)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (WrEnable_o) begin
            qAddr.push_back(WrAddress_o);
            qData.push_back(WrData_o);
        end
        if (Overrun_o) overrunCount++;
    end

    task automatic qclear();
        qAddr.delete();
        qData.delete();
    endtask

    task automatic doReset();
        @(negedge Clock);
        Reset = 1'b1;
        DataValid_i = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge Clock);
        Data_i = b;
        DataValid_i = 1'b1;
        @(negedge Clock);
        DataValid_i = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge Clock);
            if (!Busy_o) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL waitIdle: Busy_o still 1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Data_i = 8'h41;
        DataValid_i = 1'b1;
        repeat (3) @(negedge Clock);
        total++; if (WrEnable_o !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", WrEnable_o); end
        total++; if (WrAddress_o !== 12'd0) begin bad++; $display("FAIL reset_addr: got %h want 000", WrAddress_o); end
        total++; if (WrData_o !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h want 0000", WrData_o); end
        total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy_o); end
        total++; if (Overrun_o !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", Overrun_o); end
        total++; if ({CursorY_o, CursorX_o} !== 12'd0) begin bad++; $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", CursorX_o, CursorY_o); end
        Reset = 1'b0;
        DataValid_i = 1'b0;
        @(negedge Clock);
        total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL reset_ignore_valid: Busy_o got %b want 0", Busy_o); end
    endtask

    task automatic test_glyphs();
        qclear();
        @(negedge Clock);
        Data_i = 8'h41;
        DataValid_i = 1'b1;
        @(negedge Clock);
        DataValid_i = 1'b0;
        total++; if (WrEnable_o !== 1'b0) begin bad++; $display("FAIL latency_k: WrEnable_o got %b want 0", WrEnable_o); end
        @(negedge Clock);
        total++; if (WrEnable_o !== 1'b0) begin bad++; $display("FAIL latency_k1: WrEnable_o got %b want 0", WrEnable_o); end
        @(negedge Clock);
        total++; if (WrEnable_o !== 1'b1) begin bad++; $display("FAIL latency_k2: WrEnable_o got %b want 1", WrEnable_o); end
        total++; if (WrData_o !== 16'h7041 || WrAddress_o !== 12'd0) begin bad++; $display("FAIL glyph_A: got %h@%0d want 7041@0", WrData_o, WrAddress_o); end
        total++; if (CursorX_o !== 7'd1) begin bad++; $display("FAIL cursor_same_cycle: X got %0d want 1", CursorX_o); end
        sendByte(8'h42);
        waitIdle(50);
        total++; if (qAddr.size() !== 2) begin bad++; $display("FAIL glyph_count: got %0d want 2", qAddr.size()); end
        else begin
            total++; if (qAddr[1] !== 12'd1 || qData[1] !== 16'h7042) begin bad++; $display("FAIL glyph_B: got %h@%0d want 7042@1", qData[1], qAddr[1]); end
        end
        total++; if (CursorX_o !== 7'd2 || CursorY_o !== 5'd0) begin bad++; $display("FAIL glyph_cursor: got (%0d,%0d) want (2,0)", CursorX_o, CursorY_o); end
    endtask

    task automatic test_colour();
        qclear();
        sendByte(8'b1_100_0_001);
        waitIdle(50);
        total++; if (qAddr.size() !== 0) begin bad++; $display("FAIL colour_nowrite: got %0d writes want 0", qAddr.size()); end
        total++; if (CursorX_o !== 7'd2) begin bad++; $display("FAIL colour_cursor: X got %0d want 2", CursorX_o); end
        sendByte(8'h44);
        waitIdle(50);
        total++; if (qAddr.size() !== 1) begin bad++; $display("FAIL colour_count: got %0d want 1", qAddr.size()); end
        else begin
            total++; if (qAddr[0] !== 12'd2 || qData[0] !== 16'h4144) begin bad++; $display("FAIL colour_glyph: got %h@%0d want 4144@2", qData[0], qAddr[0]); end
        end
    endtask

    task automatic test_backspace();
        doReset();
        repeat (5) begin sendByte(8'h78); waitIdle(50); end
        qclear();
        sendByte(8'h45);
        sendByte(8'h7F);
        waitIdle(50);
        total++; if (qAddr.size() !== 2) begin bad++; $display("FAIL bs_count: got %0d want 2", qAddr.size()); end
        else begin
            total++; if (qAddr[0] !== 12'd5 || qData[0] !== 16'h7045) begin bad++; $display("FAIL bs_glyph: got %h@%0d want 7045@5", qData[0], qAddr[0]); end
            total++; if (qAddr[1] !== 12'd5 || qData[1] !== 16'h7020) begin bad++; $display("FAIL bs_blank: got %h@%0d want 7020@5", qData[1], qAddr[1]); end
        end
        total++; if (CursorX_o !== 7'd5 || CursorY_o !== 5'd0) begin bad++; $display("FAIL bs_cursor: got (%0d,%0d) want (5,0)", CursorX_o, CursorY_o); end
        doReset();
        qclear();
        sendByte(8'h7F);
        waitIdle(50);
        total++; if (qAddr.size() !== 0) begin bad++; $display("FAIL bs_origin: got %0d writes want 0", qAddr.size()); end
        sendByte(8'h0D);
        waitIdle(200);
        qclear();
        sendByte(8'h7F);
        waitIdle(50);
        total++; if (qAddr.size() !== 1) begin bad++; $display("FAIL bs_rowback_count: got %0d want 1", qAddr.size()); end
        else begin
            total++; if (qAddr[0] !== 12'd79 || qData[0] !== 16'h7020) begin bad++; $display("FAIL bs_rowback: got %h@%0d want 7020@79", qData[0], qAddr[0]); end
        end
        total++; if (CursorX_o !== 7'd79 || CursorY_o !== 5'd0) begin bad++; $display("FAIL bs_rowback_cursor: got (%0d,%0d) want (79,0)", CursorX_o, CursorY_o); end
    endtask

    task automatic test_newline_wrap();
        int errs = 0;
        doReset();
        repeat (29) begin sendByte(8'h0D); waitIdle(200); end
        total++; if (CursorY_o !== 5'd29 || CursorX_o !== 7'd0) begin bad++; $display("FAIL nl_row29: got (%0d,%0d) want (0,29)", CursorX_o, CursorY_o); end
        qclear();
        sendByte(8'h0D);
        waitIdle(200);
        total++; if (qAddr.size() !== 80) begin bad++; $display("FAIL nl_count: got %0d want 80", qAddr.size()); end
        for (int i = 0; i < qAddr.size(); i++)
            if (qAddr[i] !== 12'(i) || qData[i] !== 16'h7020) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL nl_fill: got %0d bad cells want 0", errs); end
        total++; if (CursorX_o !== 7'd0 || CursorY_o !== 5'd0) begin bad++; $display("FAIL nl_cursor: got (%0d,%0d) want (0,0)", CursorX_o, CursorY_o); end
    endtask

    task automatic test_line_wrap();
        int errs = 0;
        doReset();
        qclear();
        for (int i = 0; i < 81; i++) begin
            sendByte(8'(8'h21 + i));
            waitIdle(200);
        end
        total++; if (qAddr.size() !== 161) begin bad++; $display("FAIL wrap_count: got %0d want 161", qAddr.size()); end
        else begin
            total++; if (qAddr[79] !== 12'd79 || qData[79] !== 16'h7070) begin bad++; $display("FAIL wrap_glyph80: got %h@%0d want 7070@79", qData[79], qAddr[79]); end
            for (int j = 0; j < 80; j++)
                if (qAddr[80+j] !== 12'(80 + j) || qData[80+j] !== 16'h7020) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL wrap_fill: got %0d bad cells want 0", errs); end
            total++; if (qAddr[160] !== 12'd80 || qData[160] !== 16'h7071) begin bad++; $display("FAIL wrap_glyph81: got %h@%0d want 7071@80", qData[160], qAddr[160]); end
        end
        total++; if (CursorX_o !== 7'd1 || CursorY_o !== 5'd1) begin bad++; $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)", CursorX_o, CursorY_o); end
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        doReset();
        sendByte(8'h85);
        waitIdle(50);
        qclear();
        overrunCount = 0;
        sendByte(8'h0C);
        repeat (4) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            Data_i = 8'(8'h61 + i);
            DataValid_i = 1'b1;
            @(negedge Clock);
        end
        DataValid_i = 1'b0;
        waitIdle(3000);
        total++; if (qAddr.size() !== 2404) begin bad++; $display("FAIL clr_count: got %0d want 2404", qAddr.size()); end
        else begin
            for (int i = 0; i < 2400; i++)
                if (qAddr[i] !== 12'(i) || qData[i] !== 16'h7020) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL clr_fill: got %0d bad cells want 0", errs); end
            errs = 0;
            for (int j = 0; j < 4; j++)
                if (qAddr[2400+j] !== 12'(j) || qData[2400+j] !== {8'h70, 8'(8'h61 + j)}) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL clr_buffered: got %0d bad writes want 0", errs); end
        end
        total++; if (overrunCount !== 4) begin bad++; $display("FAIL clr_overrun: got %0d pulses want 4", overrunCount); end
        total++; if (CursorX_o !== 7'd4 || CursorY_o !== 5'd0) begin bad++; $display("FAIL clr_cursor: got (%0d,%0d) want (4,0)", CursorX_o, CursorY_o); end
    endtask

    task automatic test_reset_mid_fill();
        sendByte(8'h0C);
        repeat (20) @(negedge Clock);
        total++; if (WrEnable_o !== 1'b1) begin bad++; $display("FAIL midfill_active: WrEnable_o got %b want 1", WrEnable_o); end
        Reset = 1'b1;
        @(negedge Clock);
        total++; if (WrEnable_o !== 1'b0) begin bad++; $display("FAIL midfill_abort: WrEnable_o got %b want 0", WrEnable_o); end
        Reset = 1'b0;
        qclear();
        repeat (10) @(negedge Clock);
        total++; if (qAddr.size() !== 0) begin bad++; $display("FAIL midfill_nowrites: got %0d writes want 0", qAddr.size()); end
        total++; if (Busy_o !== 1'b0) begin bad++; $display("FAIL midfill_busy: got %b want 0", Busy_o); end
        total++; if (CursorX_o !== 7'd0 || CursorY_o !== 5'd0) begin bad++; $display("FAIL midfill_cursor: got (%0d,%0d) want (0,0)", CursorX_o, CursorY_o); end
    endtask

    initial begin
        test_reset();
        test_glyphs();
        test_colour();
        test_backspace();
        test_newline_wrap();
        test_line_wrap();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
